// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one shared memory port.
// Optional BUSY watchdog is enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int AW          = 64,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ready,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [63:0]   d_wdata,
    output logic          d_ready,
    output logic [63:0]   d_rdata,
    output logic          m_valid,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [63:0]   m_wdata,
    input  logic          m_ack,
    input  logic [63:0]   m_rdata,
    output logic          stall,
    output logic          err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] BUSY_I = 3'd1;
    localparam logic [2:0] BUSY_D = 3'd2;
    localparam logic [2:0] RESP_I = 3'd3;
    localparam logic [2:0] RESP_D = 3'd4;

    logic [2:0] state;
    logic       last_grant;
    logic       fetch_hi;
    logic       timeout_hit;
    logic       unused_bits;
    logic       busy;

    assign busy     = (state == BUSY_I) || (state == BUSY_D);
    assign m_valid  = busy;
    assign if_ready = (state == RESP_I);
    assign d_ready  = (state == RESP_D);
    assign stall    = (if_req & ~if_ready) | (d_req & ~d_ready);

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] busy_cnt;
    logic          err_q;

    // Fires on the last allowed BUSY cycle; a same-cycle ack takes priority.
    assign timeout_hit = busy & ~m_ack & (busy_cnt == CW'(TIMEOUT_CYC - 1));
    assign err         = err_q;
    assign unused_bits = ^if_addr[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= timeout_hit;
            if (busy)
                busy_cnt <= busy_cnt + 1'b1;
            else
                busy_cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
    assign unused_bits = ^if_addr[1:0] ^ (TIMEOUT_CYC > 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            fetch_hi   <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // last_grant=1 means data won last, so fetch wins a tie
                    if (if_req && (!d_req || last_grant)) begin
                        state      <= BUSY_I;
                        last_grant <= 1'b0;
                        fetch_hi   <= if_addr[2];
                        m_we       <= 1'b0;
                        m_addr     <= {if_addr[AW-1:3], 3'b000};
                        m_wdata    <= '0;
                    end else if (d_req) begin
                        state      <= BUSY_D;
                        last_grant <= 1'b1;
                        m_we       <= d_we;
                        m_addr     <= d_addr;
                        m_wdata    <= d_wdata;
                    end
                end
                BUSY_I: begin
                    if (m_ack) begin
                        state    <= RESP_I;
                        if_rdata <= fetch_hi ? m_rdata[63:32] : m_rdata[31:0];
                    end else if (timeout_hit) begin
                        state    <= RESP_I;
                        if_rdata <= '0;
                    end
                end
                BUSY_D: begin
                    if (m_ack) begin
                        state   <= RESP_D;
                        d_rdata <= m_we ? 64'h0 : m_rdata;
                    end else if (timeout_hit) begin
                        state   <= RESP_D;
                        d_rdata <= '0;
                    end
                end
                RESP_I:  state <= IDLE;
                RESP_D:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
